// File: rtl/demultiplexer_1_to_2_stream_pkg.sv
// -----------------------------------------------------------------------------
// demultiplexer_1_to_2_stream_pkg
// Shared types and helpers for the 1-to-2 stream demultiplexer slice.
//   channel_e       : names the two destination channels.
//   push_enables()  : turns a selector and an accepted push into one-hot
//                     per-channel write enables (bit k drives FIFO k).
// -----------------------------------------------------------------------------
package demultiplexer_1_to_2_stream_pkg;

   typedef enum logic {
      CH_0 = 1'b0,
      CH_1 = 1'b1
   } channel_e;

   localparam int DEFAULT_N_BITS = 32;
   localparam int DEFAULT_DEPTH  = 2;

   // One-hot write enables: only the selected channel sees the push.
   function automatic logic [1:0] push_enables(input logic sel, input logic push);
      logic [1:0] en;
      en = 2'b00;
      if (push) begin
         if (sel == CH_1) begin
            en = 2'b10;
         end else begin
            en = 2'b01;
         end
      end else begin
         en = 2'b00;
      end
      return en;
   endfunction

endpackage : demultiplexer_1_to_2_stream_pkg

// File: rtl/demultiplexer_1_to_2_stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Small registered FIFO used as the per-channel buffer of the demultiplexer.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   push       : write data_in at the next edge (ignored while full)
//   data_in    : word to store
//   pop        : drop the head at the next edge (ignored while empty)
//   head       : word at the read pointer (zero after reset)
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module stream_fifo #(
   parameter int N_BITS = 32,
   parameter int DEPTH  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [N_BITS-1:0]       data_in,
   input  logic                    pop,
   output logic [N_BITS-1:0]       head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);
   import demultiplexer_1_to_2_stream_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_ZERO   = (PTR_W + 1)'(0);
   localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W + 1)'(DEPTH);

   logic [N_BITS-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic [PTR_W:0]    count_next_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;

   assign full_s  = (count_r == CNT_FULL);
   assign empty_s = (count_r == CNT_ZERO);

   // A full FIFO rejects writes and an empty one ignores reads, so the
   // pointers can never run past each other whatever the caller does.
   assign push_s = push & ~full_s;
   assign pop_s  = pop  & ~empty_s;

   // Occupancy bookkeeping: simultaneous push and pop leaves the count alone.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         2'b11:   count_next_s = count_r;
         2'b00:   count_next_s = count_r;
         default: count_next_s = count_r;
      endcase
   end

   // Storage and pointer state; reset wipes every entry so nothing stale leaks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {N_BITS{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_next_s;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = full_s;
   assign empty = empty_s;
   assign count = count_r;

endmodule : stream_fifo

// File: rtl/demultiplexer_1_to_2_stream.sv
// -----------------------------------------------------------------------------
// demultiplexer_1_to_2_stream
// Routes each word of one valid/ready stream to one of two output streams,
// chosen per word by selector_i. Each channel has its own FIFO so a stalled
// consumer only blocks words addressed to it.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   selector_i                 : destination of the current word (0/1)
//   in_valid_i, data_i         : input stream
//   in_ready_o                 : selected channel has room this cycle
//   out_valid_k_o, data_k_o    : channel k head (k = 0, 1)
//   out_ready_k_i              : channel k consumer accepts
//   count_k_o                  : channel k occupancy
// in_ready_o depends only on registered occupancy and selector_i; a pop on a
// full channel frees the slot for the following cycle, never the current one.
// -----------------------------------------------------------------------------
module demultiplexer_1_to_2_stream #(
   parameter int N_BITS = 32,
   parameter int DEPTH  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    selector_i,
   input  logic                    in_valid_i,
   input  logic [N_BITS-1:0]       data_i,
   output logic                    in_ready_o,
   output logic                    out_valid_0_o,
   output logic [N_BITS-1:0]       data_0_o,
   input  logic                    out_ready_0_i,
   output logic                    out_valid_1_o,
   output logic [N_BITS-1:0]       data_1_o,
   input  logic                    out_ready_1_i,
   output logic [$clog2(DEPTH):0]  count_0_o,
   output logic [$clog2(DEPTH):0]  count_1_o
);
   import demultiplexer_1_to_2_stream_pkg::*;

   logic              full_0_s;
   logic              full_1_s;
   logic              empty_0_s;
   logic              empty_1_s;
   logic              in_ready_s;
   logic              push_s;
   logic [1:0]        push_en_s;
   logic              pop_0_s;
   logic              pop_1_s;

   // Ready reflects only the channel the current word is aimed at.
   always_comb begin
      in_ready_s = 1'b0;
      if (selector_i == CH_1) begin
         in_ready_s = ~full_1_s;
      end else begin
         in_ready_s = ~full_0_s;
      end
   end

   assign push_s    = in_valid_i & in_ready_s;
   assign push_en_s = push_enables(selector_i, push_s);

   assign out_valid_0_o = ~empty_0_s;
   assign out_valid_1_o = ~empty_1_s;
   assign pop_0_s       = out_valid_0_o & out_ready_0_i;
   assign pop_1_s       = out_valid_1_o & out_ready_1_i;
   assign in_ready_o    = in_ready_s;

   stream_fifo #(
      .N_BITS (N_BITS),
      .DEPTH  (DEPTH)
   ) u_fifo_0 (
      .clk     (clk),
      .reset   (reset),
      .push    (push_en_s[0]),
      .data_in (data_i),
      .pop     (pop_0_s),
      .head    (data_0_o),
      .full    (full_0_s),
      .empty   (empty_0_s),
      .count   (count_0_o)
   );

   stream_fifo #(
      .N_BITS (N_BITS),
      .DEPTH  (DEPTH)
   ) u_fifo_1 (
      .clk     (clk),
      .reset   (reset),
      .push    (push_en_s[1]),
      .data_in (data_i),
      .pop     (pop_1_s),
      .head    (data_1_o),
      .full    (full_1_s),
      .empty   (empty_1_s),
      .count   (count_1_o)
   );

endmodule : demultiplexer_1_to_2_stream

// File: tb/tb_demultiplexer_1_to_2_stream.sv
// -----------------------------------------------------------------------------
// tb_demultiplexer_1_to_2_stream
// Self-checking bench: directed scenarios plus random traffic, compared
// against a queue-based reference model of the two channels.
// -----------------------------------------------------------------------------
module tb_demultiplexer_1_to_2_stream;
   localparam int N_BITS = 32;
   localparam int DEPTH  = 2;

   logic              clk;
   logic              reset;
   logic              selector_i;
   logic              in_valid_i;
   logic [N_BITS-1:0] data_i;
   logic              in_ready_o;
   logic              out_valid_0_o;
   logic [N_BITS-1:0] data_0_o;
   logic              out_ready_0_i;
   logic              out_valid_1_o;
   logic [N_BITS-1:0] data_1_o;
   logic              out_ready_1_i;
   logic [1:0]        count_0_o;
   logic [1:0]        count_1_o;

   int tests_run;
   int tests_failed;

   // Reference model: one queue per channel, head at index 0.
   logic [N_BITS-1:0] q0[$];
   logic [N_BITS-1:0] q1[$];

   demultiplexer_1_to_2_stream #(.N_BITS(N_BITS), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .selector_i    (selector_i),
      .in_valid_i    (in_valid_i),
      .data_i        (data_i),
      .in_ready_o    (in_ready_o),
      .out_valid_0_o (out_valid_0_o),
      .data_0_o      (data_0_o),
      .out_ready_0_i (out_ready_0_i),
      .out_valid_1_o (out_valid_1_o),
      .data_1_o      (data_1_o),
      .out_ready_1_i (out_ready_1_i),
      .count_0_o     (count_0_o),
      .count_1_o     (count_1_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Compare registered outputs against the model (called away from posedge).
   task automatic check_outputs();
      check_eq("valid_0", 64'(out_valid_0_o), 64'(q0.size() != 0));
      check_eq("valid_1", 64'(out_valid_1_o), 64'(q1.size() != 0));
      check_eq("count_0", 64'(count_0_o), 64'(q0.size()));
      check_eq("count_1", 64'(count_1_o), 64'(q1.size()));
      if (q0.size() != 0) check_eq("data_0", 64'(data_0_o), 64'(q0[0]));
      if (q1.size() != 0) check_eq("data_1", 64'(data_1_o), 64'(q1[0]));
   endtask

   // One clock cycle, starting and ending at a negedge. Reports whether the
   // model says the input word was accepted.
   task automatic cycle(input logic sel, input logic vld, input logic [N_BITS-1:0] d,
                        input logic r0, input logic r1, output logic accepted);
      int  sz_sel;
      logic exp_ready;
      selector_i    = sel;
      in_valid_i    = vld;
      data_i        = d;
      out_ready_0_i = r0;
      out_ready_1_i = r1;
      #1;
      sz_sel    = sel ? q1.size() : q0.size();
      exp_ready = (sz_sel < DEPTH);
      check_eq("in_ready", 64'(in_ready_o), 64'(exp_ready));
      accepted = vld && exp_ready;
      // Pops use pre-edge occupancy, then the accepted word joins its queue.
      if (r0 && q0.size() != 0) void'(q0.pop_front());
      if (r1 && q1.size() != 0) void'(q1.pop_front());
      if (accepted) begin
         if (sel) q1.push_back(d);
         else     q0.push_back(d);
      end
      @(negedge clk);
      check_outputs();
   endtask

   // Present a word until accepted, bounded; an expired bound is a failure.
   task automatic send(input logic sel, input logic [N_BITS-1:0] d,
                       input logic r0, input logic r1);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         cycle(sel, 1'b1, d, r0, r1, acc);
         n++;
      end
      check_eq("send_accepted", 64'(acc), 64'(1));
   endtask

   task automatic check_reset_state();
      check_eq("rst_in_ready", 64'(in_ready_o), 64'(1));
      check_eq("rst_valid_0", 64'(out_valid_0_o), 64'(0));
      check_eq("rst_valid_1", 64'(out_valid_1_o), 64'(0));
      check_eq("rst_count_0", 64'(count_0_o), 64'(0));
      check_eq("rst_count_1", 64'(count_1_o), 64'(0));
      check_eq("rst_data_0", 64'(data_0_o), 64'(0));
      check_eq("rst_data_1", 64'(data_1_o), 64'(0));
   endtask

   initial begin
      logic acc;
      logic tog;
      tests_run    = 0;
      tests_failed = 0;
      selector_i    = 1'b0;
      in_valid_i    = 1'b0;
      data_i        = '0;
      out_ready_0_i = 1'b0;
      out_ready_1_i = 1'b0;

      // Reset then idle.
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_reset_state();
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
      check_reset_state();

      // Single routing.
      cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, acc);
      check_eq("route_ch0_head", 64'(data_0_o), 64'(32'hDEADBEEF));
      cycle(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, acc);
      check_eq("route_ch0_gone", 64'(out_valid_0_o), 64'(0));
      check_eq("route_ch1_head", 64'(data_1_o), 64'(32'h12345678));
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
      check_eq("route_ch1_gone", 64'(out_valid_1_o), 64'(0));

      // Full / backpressure on channel 0, channel 1 still open.
      cycle(1'b0, 1'b1, 32'h1, 1'b0, 1'b0, acc);
      cycle(1'b0, 1'b1, 32'h2, 1'b0, 1'b0, acc);
      check_eq("full_count_0", 64'(count_0_o), 64'(2));
      cycle(1'b0, 1'b1, 32'h3, 1'b0, 1'b0, acc);
      check_eq("full_stall", 64'(acc), 64'(0));
      cycle(1'b1, 1'b1, 32'hA, 1'b0, 1'b0, acc);
      check_eq("other_ch_accepted", 64'(acc), 64'(1));
      // First cycle with ready high: pop frees the slot only next cycle.
      cycle(1'b0, 1'b1, 32'h3, 1'b1, 1'b0, acc);
      check_eq("no_same_cycle_free", 64'(acc), 64'(0));
      send(1'b0, 32'h3, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
      check_eq("drain_ch0", 64'(count_0_o), 64'(0));

      // Simultaneous push/pop on channel 1 (holds 0xA).
      cycle(1'b1, 1'b1, 32'hB, 1'b0, 1'b1, acc);
      check_eq("pushpop_count_1", 64'(count_1_o), 64'(1));
      check_eq("pushpop_head_1", 64'(data_1_o), 64'(32'hB));
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, acc);

      // Wrap-around with toggling consumer ready.
      tog = 1'b1;
      for (int i = 0; i < 8; i++) begin
         acc = 1'b0;
         for (int n = 0; n < 20 && !acc; n++) begin
            cycle(1'b0, 1'b1, 32'(32'h10 + i), tog, 1'b1, acc);
            tog = ~tog;
         end
         check_eq("wrap_accepted", 64'(acc), 64'(1));
      end
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b0, 32'h0, tog, 1'b1, acc);
         tog = ~tog;
      end
      check_eq("wrap_drained", 64'(count_0_o), 64'(0));

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 32'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), acc);
      end

      // Async reset mid-operation with both FIFOs full.
      cycle(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0, acc);
      cycle(1'b0, 1'b1, 32'hC1, 1'b0, 1'b0, acc);
      cycle(1'b0, 1'b1, 32'hC2, 1'b0, 1'b0, acc);
      cycle(1'b1, 1'b1, 32'hD0, 1'b0, 1'b0, acc);
      cycle(1'b1, 1'b1, 32'hD1, 1'b0, 1'b0, acc);
      cycle(1'b1, 1'b1, 32'hD2, 1'b0, 1'b0, acc);
      check_eq("pre_rst_count_0", 64'(count_0_o), 64'(2));
      check_eq("pre_rst_count_1", 64'(count_1_o), 64'(2));
      in_valid_i = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      q0.delete();
      q1.delete();
      check_reset_state();
      @(negedge clk);
      reset = 1'b0;
      check_reset_state();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
      check_reset_state();
      send(1'b1, 32'h55AA55AA, 1'b0, 1'b0);
      check_eq("post_rst_head_1", 64'(data_1_o), 64'(32'h55AA55AA));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_demultiplexer_1_to_2_stream

// File: doc/demultiplexer_1_to_2_stream.md
Name: demultiplexer_1_to_2_stream

Overview:
- Steering counterpart of the datapath 2-to-1 selector. Takes one valid/ready input stream and routes each word to one of two output streams, chosen per word by a selector bit.
- Each output channel has a small registered FIFO, so a stalled destination does not block traffic bound for the other one.
- Used between pipeline producers and two independent consumers, e.g. splitting a result bus towards the register-file write port or a memory/debug sink.

Parameters:
- N_BITS, 32, data word width.
- DEPTH, 2, entries per output FIFO. Must be a power of two and ≥2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- selector_i  input  1  destination of the current input word (0 → channel 0, 1 → channel 1).
- in_valid_i  input  1  input word present.
- data_i  input  N_BITS  input word.
- in_ready_o  output  1  block can accept the word on the selected channel this cycle.
- out_valid_0_o  output  1  channel 0 head valid.
- data_0_o  output  N_BITS  channel 0 head word.
- out_ready_0_i  input  1  channel 0 consumer accepts.
- out_valid_1_o  output  1  channel 1 head valid.
- data_1_o  output  N_BITS  channel 1 head word.
- out_ready_1_i  input  1  channel 1 consumer accepts.
- count_0_o  output  $clog2(DEPTH)+1  channel 0 occupancy.
- count_1_o  output  $clog2(DEPTH)+1  channel 1 occupancy.

Behaviour:
- Reset (async assert, sync release):
  - Read/write pointers and counts are 0.
  - out_valid_*_o = 0, data_*_o = 0 (storage cleared).
  - in_ready_o = 1.
  - Reset mid-transfer discards all buffered words; no partial state survives.
- Input acceptance:
  - in_ready_o = !full[selector_i].
  - It is a function of registered state and selector_i only. There is no combinational path from out_ready_*_i to in_ready_o.
  - A push occurs when in_valid_i & in_ready_o. The word is written into FIFO[selector_i] at the clock edge.
- Output handshake:
  - out_valid_k_o = (count_k != 0).
  - data_k_o = word at the read pointer. It is stable while valid and not yet accepted.
  - A pop occurs when out_valid_k_o & out_ready_k_i.
- Latency:
  - A word accepted at edge t is visible on its channel outputs after edge t (one-cycle latency) when that FIFO was empty.
  - There is no same-cycle bypass.
- Ordering:
  - FIFO order is preserved per channel.
  - There is no ordering relation between the two channels.
- Count update per channel:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Full:
  - When count_k = DEPTH, words selecting k stall (in_ready_o = 0).
  - Words selecting the other channel are still accepted.
  - A pop on a full channel frees the slot for the next cycle, not the current one.
- Empty:
  - out_valid_k_o = 0. out_ready_k_i is ignored and the pointers do not move.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- Selector change while in_valid_i is high and stalled:
  - Legal. in_ready_o re-evaluates against the new channel in the same cycle.
  - The producer is responsible for holding selector_i/data_i stable until the word is accepted.
- X on selector_i while in_valid_i = 0: no effect.

Decomposition:
- No shared package required. DEPTH and the derived pointer width are local parameters.
- Natural sub-module: stream_fifo (parameters N_BITS, DEPTH; ports push, pop, data in, head out, full, empty, count). It is instantiated twice.
- The top level holds only the steering logic: push enables from selector_i, and in_ready_o muxing.

Test Plan (N_BITS=32, DEPTH=2):
- Reset then idle: reset high for 2 cycles, then low → in_ready_o=1, out_valid_0_o=out_valid_1_o=0, counts 0, data_*_o=0.
- Single routing: push 0xDEADBEEF sel=0, then 0x12345678 sel=1, both out_ready high → channel 0 shows 0xDEADBEEF one cycle after acceptance; channel 1 shows 0x12345678 one cycle later; each valid for exactly 1 cycle.
- Full/backpressure on one channel:
  - Stimulus: out_ready_0_i=0; push 0x1, 0x2, 0x3 all sel=0.
  - Required: count_0_o=2 after two pushes, in_ready_o=0 on the third; a sel=1 word 0xA is still accepted.
  - Then raise out_ready_0_i: 0x1, 0x2, 0x3 emerge in order.
- Simultaneous push/pop: channel 1 count=1, push sel=1 with out_ready_1_i=1 → count_1_o stays 1; heads are 0xA then 0xB in order.
- Wrap-around: stream 8 words 0x10..0x17 to channel 0 with out_ready toggling 1,0 each cycle → all 8 delivered in order; count never exceeds 2, never underflows.
- Async reset mid-operation: both FIFOs full, assert reset between clock edges → outputs clear immediately, without waiting for an edge; after release no stale words appear.
